// File: rtl/poly_pkg.sv
// poly_pkg: shared constants for the polynomial evaluator operand loader.
//   LOAD/FIRE/WAIT  loader FSM state encodings
//   IDX_X..IDX_C    operand register indices, in the order words arrive
//   WORD_LENGTH_DEF default operand width
package poly_pkg;
   localparam logic [1:0] LOAD = 2'd0;
   localparam logic [1:0] FIRE = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] IDX_X = 2'd0;
   localparam logic [1:0] IDX_A = 2'd1;
   localparam logic [1:0] IDX_B = 2'd2;
   localparam logic [1:0] IDX_C = 2'd3;
   localparam int WORD_LENGTH_DEF = 8;
endpackage

// File: rtl/poly_operand_regfile.sv
// poly_operand_regfile: four operand registers written one at a time by index.
//   clk, reset      clock, asynchronous active-high reset (registers clear to 0)
//   we, idx, wd     write enable, target index (0:X 1:A 2:B 3:C), write data
//   x, a, b, c      held operand values
module poly_operand_regfile
   import poly_pkg::*;
#(
   parameter int WORD_LENGTH = WORD_LENGTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic [1:0]             idx,
   input  logic [WORD_LENGTH-1:0] wd,
   output logic [WORD_LENGTH-1:0] x,
   output logic [WORD_LENGTH-1:0] a,
   output logic [WORD_LENGTH-1:0] b,
   output logic [WORD_LENGTH-1:0] c
);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         x <= '0;
         a <= '0;
         b <= '0;
         c <= '0;
      end else if (we) begin
         x <= idx == IDX_X ? wd : x;
         a <= idx == IDX_A ? wd : a;
         b <= idx == IDX_B ? wd : b;
         c <= idx == IDX_C ? wd : c;
      end
endmodule

// File: rtl/poly_operand_loader.sv
// poly_operand_loader: collects X, A, B, C over a valid/ready stream, pulses
// start to the control FSM and holds the operands until or_en marks completion.
// Optional watchdog on the WAIT state enabled by macro POLY_LOADER_TIMEOUT_EN.
//   clk, reset          clock, asynchronous active-high reset
//   in_valid, in_data   upstream operand words, order X, A, B, C
//   in_ready            high in LOAD (and not in reset)
//   or_en               evaluation complete; honoured only in WAIT
//   clear_err           synchronous clear of error (watchdog build only)
//   start               one-cycle registered pulse after word C is accepted
//   x_o, a_o, b_o, c_o  held operands
//   busy                high in FIRE and WAIT
//   error               sticky watchdog error (tied 0 without the watchdog)
module poly_operand_loader
   import poly_pkg::*;
#(
   parameter int WORD_LENGTH    = WORD_LENGTH_DEF,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [WORD_LENGTH-1:0] in_data,
   output logic                   in_ready,
   input  logic                   or_en,
   input  logic                   clear_err,
   output logic                   start,
   output logic [WORD_LENGTH-1:0] x_o,
   output logic [WORD_LENGTH-1:0] a_o,
   output logic [WORD_LENGTH-1:0] b_o,
   output logic [WORD_LENGTH-1:0] c_o,
   output logic                   busy,
   output logic                   error
);
   logic [1:0] state;
   logic [1:0] word_cnt;
   logic       xfer;
   logic       timeout;

   // in_ready is masked by reset because state already reads LOAD while reset is held
   assign in_ready = state == LOAD && !reset;
   assign xfer     = in_valid && in_ready;
   assign busy     = state != LOAD;

`ifdef POLY_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wd_cnt;
   // counter is 0 on the first WAIT cycle, so it reads TIMEOUT_CYCLES-1 on the
   // TIMEOUT_CYCLES-th WAIT cycle; or_en on that same cycle takes priority
   assign timeout = state == WAIT && !or_en && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wd_cnt <= '0;
         error  <= 1'b0;
      end else begin
         wd_cnt <= state == WAIT ? wd_cnt + TW'(1) : '0;
         error  <= timeout ? 1'b1 : clear_err ? 1'b0 : error;
      end
`else
   logic unused;
   assign unused  = clear_err | (TIMEOUT_CYCLES < 7);
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= LOAD;
         word_cnt <= 2'd0;
         start    <= 1'b0;
      end else begin
         start    <= xfer && word_cnt == IDX_C;
         word_cnt <= xfer ? word_cnt + 2'd1 : word_cnt;
         state    <= state == LOAD ? (xfer && word_cnt == IDX_C ? FIRE : LOAD) :
                     state == FIRE ? WAIT :
                     (or_en || timeout) ? LOAD : WAIT;
      end

   poly_operand_regfile #(.WORD_LENGTH(WORD_LENGTH)) u_regfile (
      .clk  (clk),
      .reset(reset),
      .we   (xfer),
      .idx  (word_cnt),
      .wd   (in_data),
      .x    (x_o),
      .a    (a_o),
      .b    (b_o),
      .c    (c_o)
   );
endmodule

// File: tb/tb_poly_operand_loader.sv
// tb_poly_operand_loader: scoreboard bench; expected operand sets are queued
// when a set is sent and checked by a monitor on every start pulse.
module tb_poly_operand_loader;
   typedef struct packed {
      logic [7:0] x;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       or_en = 1'b0;
   logic       clear_err = 1'b0;
   logic       start;
   logic [7:0] x_o, a_o, b_o, c_o;
   logic       busy;
   logic       error;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   poly_operand_loader #(.WORD_LENGTH(8), .TIMEOUT_CYCLES(15)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .or_en    (or_en),
      .clear_err(clear_err),
      .start    (start),
      .x_o      (x_o),
      .a_o      (a_o),
      .b_o      (b_o),
      .c_o      (c_o),
      .busy     (busy),
      .error    (error)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every start pulse must match the oldest queued operand set
   always @(negedge clk)
      if (start) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL start_unexpected: got start=1 expected no pending set at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_x", x_o, e.x);
            chk("mon_a", a_o, e.a);
            chk("mon_b", b_o, e.b);
            chk("mon_c", c_o, e.c);
         end
      end

   task automatic send_set(input logic [7:0] x, a, b, c);
      exp_q.push_back('{x, a, b, c});
      in_valid = 1'b1;
      in_data = x; @(posedge clk); #1;
      in_data = a; @(posedge clk); #1;
      in_data = b; @(posedge clk); #1;
      in_data = c; @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // entered just after the edge accepting C; or_en asserted 7 cycles after start
   task automatic fire_release(input logic fire_oren, input logic [7:0] x, a, b, c);
      or_en = fire_oren;
      @(negedge clk);
      chk("fire_start", start, 1);
      chk("fire_busy", busy, 1);
      chk("fire_ready", in_ready, 0);
      @(posedge clk); #1;
      or_en = 1'b0;
      @(negedge clk);
      chk("wait_start", start, 0);
      chk("wait_busy", busy, 1);
      chk("wait_ready", in_ready, 0);
      repeat (6) @(posedge clk);
      #1;
      or_en = 1'b1;
      @(negedge clk);
      chk("wait7_busy", busy, 1);
      @(posedge clk); #1;
      or_en = 1'b0;
      @(negedge clk);
      chk("done_busy", busy, 0);
      chk("done_ready", in_ready, 1);
      chk("hold_ops", {x_o, a_o, b_o, c_o}, {x, a, b, c});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic       pv[7];
      logic [7:0] tw[4];
      int         k;
      pv = '{1, 0, 0, 1, 1, 0, 1};
      tw = '{8'd9, 8'd8, 8'd6, 8'd4};
      repeat (2) @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", start, 0);
      chk("rst_error", error, 0);
      chk("rst_ops", {x_o, a_o, b_o, c_o}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_ready", in_ready, 1);

      // basic set with in_valid held high
      send_set(8'd3, 8'd2, 8'd5, 8'd7);
      fire_release(1'b0, 8'd3, 8'd2, 8'd5, 8'd7);

      // throttled load, or_en high on every stall cycle in LOAD
      @(posedge clk); #1;
      exp_q.push_back('{8'd9, 8'd8, 8'd6, 8'd4});
      k = 0;
      for (int i = 0; i < 7; i++) begin
         in_valid = pv[i];
         or_en = !pv[i];
         in_data = pv[i] ? tw[k] : 8'hEE;
         @(negedge clk);
         chk("thr_start", start, 0);
         chk("thr_busy", busy, 0);
         chk("thr_ready", in_ready, 1);
         @(posedge clk); #1;
         if (pv[i]) k++;
         if (i == 4) chk("thr_partial", {x_o, a_o, b_o, c_o}, {8'd9, 8'd8, 8'd6, 8'd7});
      end
      in_valid = 1'b0;
      fire_release(1'b1, 8'd9, 8'd8, 8'd6, 8'd4);

      // reset after two words discards the partial set
      in_valid = 1'b1;
      in_data = 8'd11; @(posedge clk); #1;
      in_data = 8'd22; @(posedge clk); #1;
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_ops", {x_o, a_o, b_o, c_o}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_a", a_o, 0);
      chk("post_rst_busy", busy, 0);
      @(posedge clk); #1;
      send_set(8'd33, 8'd44, 8'd55, 8'd66);
      fire_release(1'b0, 8'd33, 8'd44, 8'd55, 8'd66);

`ifdef POLY_LOADER_TIMEOUT_EN
      // watchdog: no or_en, error after 15 WAIT cycles
      @(posedge clk); #1;
      send_set(8'd1, 8'd2, 8'd3, 8'd4);
      @(negedge clk);
      chk("to_fire_start", start, 1);
      repeat (15) @(negedge clk);
      chk("to_wait15_error", error, 0);
      chk("to_wait15_busy", busy, 1);
      @(negedge clk);
      chk("to_error", error, 1);
      chk("to_busy", busy, 0);
      chk("to_ready", in_ready, 1);
      @(posedge clk); #1;
      clear_err = 1'b1;
      @(posedge clk); #1;
      clear_err = 1'b0;
      @(negedge clk);
      chk("clr_error", error, 0);
      // or_en on the 15th WAIT cycle beats the timeout
      @(posedge clk); #1;
      send_set(8'd5, 8'd6, 8'd7, 8'd8);
      @(negedge clk);
      chk("to2_fire_start", start, 1);
      repeat (15) @(negedge clk);
      or_en = 1'b1;
      @(posedge clk); #1;
      or_en = 1'b0;
      @(negedge clk);
      chk("to2_error", error, 0);
      chk("to2_busy", busy, 0);
`endif

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/poly_operand_loader.md
Name: poly_operand_loader

Overview:
- Upstream stage of the polynomial evaluator (y = A*x^2 + B*x + C).
- Accepts operand words serially over a valid/ready stream, in fixed order X, A, B, C.
- Holds the four operands stable for the datapath, issues a one-cycle start pulse to the control FSM, then waits for the FSM's output-register enable before accepting the next operand set.

Parameters:
- WORD_LENGTH, 8, width of each operand word.
- TIMEOUT_CYCLES, 15, WAIT-state watchdog limit in cycles. Used only with the optional feature; must be >= 7.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_data  in  WORD_LENGTH  upstream operand word.
- in_ready  out  1  loader can accept a word this cycle.
- or_en  in  1  FSM output-register enable; marks the evaluation as complete.
- clear_err  in  1  synchronous clear of the sticky error flag.
- start  out  1  one-cycle start pulse to the control FSM.
- x_o, a_o, b_o, c_o  out  WORD_LENGTH each  held operands for the datapath.
- busy  out  1  high from the FIRE state until completion.
- error  out  1  sticky watchdog error.

Behaviour:
- Reset values (async, while reset=1):
  - State=LOAD, word_cnt=0.
  - All operand registers 0.
  - start=0, busy=0, error=0, in_ready=0 during reset.
  - The watchdog counter is cleared.
- States: LOAD, FIRE, WAIT.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid && in_ready. in_data is written to the register selected by word_cnt (0:X, 1:A, 2:B, 3:C), then word_cnt increments.
  - On the transfer with word_cnt=3: word_cnt wraps to 0 and the next state is FIRE.
  - in_valid=0 stalls the load with no side effects. A partial set is retained indefinitely.
- FIRE:
  - Lasts exactly one cycle.
  - start is a registered output, high only during this cycle.
  - in_ready=0, busy=1.
  - Next state is WAIT.
- WAIT:
  - busy=1, in_ready=0.
  - Operand registers are frozen.
  - When or_en=1 is sampled, the next state is LOAD. busy drops and in_ready rises the following cycle.
  - Minimum start-to-or_en distance is 7 cycles. Load-to-load turnaround is therefore at least 4 (load) + 1 (FIRE) + 7 cycles.
- or_en outside WAIT (LOAD or FIRE) is ignored and has no side effects.
- Operand outputs change only on LOAD transfers. x_o through c_o are valid and stable from the first FIRE cycle until WAIT exits.
- error:
  - Set only by the watchdog.
  - Cleared synchronously when clear_err=1.
  - If a set event and clear_err occur in the same cycle, set wins.
  - error does not block operation.
- Reset mid-operation (any state): abort immediately to the reset values. Any partially loaded set is discarded.
- Fixed output latency: start rises one cycle after the clock edge that accepts word C.

Optional Feature:
- Macro: POLY_LOADER_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - If the counter reaches TIMEOUT_CYCLES with no or_en: error<=1 and state->LOAD (recovery).
  - If or_en coincides with the timeout cycle, or_en wins and no error is raised.
- Not defined:
  - No counter is present.
  - WAIT lasts indefinitely until or_en.
  - error is tied to 0; clear_err is unused.

Decomposition:
- Shared package poly_pkg:
  - State encoding constants LOAD=2'd0, FIRE=2'd1, WAIT=2'd2.
  - Operand index constants IDX_X=0, IDX_A=1, IDX_B=2, IDX_C=3.
  - Default WORD_LENGTH.
- One sub-module: poly_operand_regfile. It holds the four WORD_LENGTH registers with write-enable and 2-bit index, async active-high reset to 0.
- The FSM, word counter and watchdog stay in the top module.

Test Plan:
- Reset, then stream X=3, A=2, B=5, C=7 with in_valid held high -> x_o=3, a_o=2, b_o=5, c_o=7. start high exactly one cycle after C is accepted; busy=1, in_ready=0.
- In WAIT, pulse or_en 7 cycles after start -> busy=0 and in_ready=1 the next cycle; operands unchanged until the next transfer.
- Throttle: toggle in_valid 1,0,0,1,1,0,1 -> exactly 4 words accepted in order. No start until the 4th word; stall cycles cause no writes.
- or_en=1 during LOAD and during the FIRE cycle -> no state change and no busy/in_ready change.
- Assert reset after 2 words, release, then send 4 new words -> only the new words appear; the earlier A value is gone (register=0 before reload).
- With POLY_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=15:
  - Withhold or_en -> error=1 after 15 WAIT cycles and state returns to LOAD.
  - Assert clear_err -> error=0.
  - With or_en on the 15th cycle -> no error.
